// File: rtl/cond_move_wb_pkg.sv
// cond_move_wb_pkg: conditional-move mode encodings shared by decode, hazard and WB logic
package cond_move_wb_pkg;
   typedef enum logic [1:0] {
      COND_NONE = 2'b00,
      COND_MOVZ = 2'b01,
      COND_MOVN = 2'b10,
      COND_RSVD = 2'b11
   } cond_mode_e;
endpackage

// File: rtl/cond_write_resolve.sv
// cond_write_resolve: combinational register-write enable for normal, MOVZ and MOVN slots
module cond_write_resolve
   import cond_move_wb_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter bit ZERO_GUARD = 1'b1
) (
   input  logic              valid_i,
   input  logic              reg_write_i,
   input  cond_mode_e        mode_i,
   input  logic [DATA_W-1:0] test_i,
   input  logic [REG_AW-1:0] write_reg_i,
   output logic              resolve_o,
   output logic              cond_move_o
);
   logic cond;
   logic guard;
   always_comb begin
      cond        = mode_i == COND_NONE ? reg_write_i :
                    mode_i == COND_MOVZ ? ~|test_i :
                    mode_i == COND_MOVN ? |test_i : 1'b0;
      guard       = ZERO_GUARD && write_reg_i == '0;
      resolve_o   = valid_i & cond & ~guard;
      cond_move_o = mode_i == COND_MOVZ || mode_i == COND_MOVN;
   end
endmodule

// File: rtl/cond_move_wb.sv
// cond_move_wb: MEM->WB conditional-write stage with stall/flush and a saturating
// count of conditional moves that resolved to no write.
module cond_move_wb
   import cond_move_wb_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int CNT_W      = 16,
   parameter bit ZERO_GUARD = 1'b1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              In_Valid,
   input  logic              In_RegWrite,
   input  logic [1:0]        In_CondMode,
   input  logic [DATA_W-1:0] In_Test,
   input  logic [REG_AW-1:0] In_WriteReg,
   input  logic [DATA_W-1:0] In_WriteData,
   output logic              Resolve_Write,
   output logic              WB_Valid,
   output logic              WB_Write,
   output logic [REG_AW-1:0] WB_WriteReg,
   output logic [DATA_W-1:0] WB_WriteData,
   output logic [CNT_W-1:0]  Suppressed_Cnt
);
   logic              cond_move;
   logic              accept;
   logic              valid_q, valid_d;
   logic              write_q, write_d;
   logic [REG_AW-1:0] reg_q, reg_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   cond_write_resolve #(
      .DATA_W     (DATA_W),
      .REG_AW     (REG_AW),
      .ZERO_GUARD (ZERO_GUARD)
   ) u_resolve (
      .valid_i     (In_Valid),
      .reg_write_i (In_RegWrite),
      .mode_i      (cond_mode_e'(In_CondMode)),
      .test_i      (In_Test),
      .write_reg_i (In_WriteReg),
      .resolve_o   (Resolve_Write),
      .cond_move_o (cond_move)
   );

   // Flush squashes valid/write but keeps address and data as they were.
   always_comb begin
      accept  = ~Stall & ~Flush;
      valid_d = Flush ? 1'b0 : Stall ? valid_q : In_Valid;
      write_d = Flush ? 1'b0 : Stall ? write_q : Resolve_Write;
      reg_d   = accept ? In_WriteReg : reg_q;
      data_d  = accept ? In_WriteData : data_q;
      cnt_d   = (accept && In_Valid && cond_move && !Resolve_Write && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         valid_q <= 1'b0;
         write_q <= 1'b0;
         reg_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         write_q <= write_d;
         reg_q   <= reg_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign WB_Valid       = valid_q;
   assign WB_Write       = write_q;
   assign WB_WriteReg    = reg_q;
   assign WB_WriteData   = data_q;
   assign Suppressed_Cnt = cnt_q;
endmodule
